// File: rtl/key_pkg.sv
// ============================================================================
// key_pkg : shared types and constants for the keypad scanner and the
//           calculator control FSM (states, scan results, rows, key legend)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DEB     = 2'd1,
        ST_PRESSED = 2'd2,
        ST_REL_DEB = 2'd3
    } key_state_e;

    typedef enum logic [1:0] {
        SCAN_NONE   = 2'd0,
        SCAN_SINGLE = 2'd1,
        SCAN_MULTI  = 2'd2
    } scan_res_e;

    localparam logic [3:0] c_row0_n = 4'b1110;
    localparam logic [3:0] c_row1_n = 4'b1101;
    localparam logic [3:0] c_row2_n = 4'b1011;
    localparam logic [3:0] c_row3_n = 4'b0111;

    // Operator symbols; digits 0-9 use their own value as symbol.
    localparam logic [3:0] c_sym_add = 4'hA;
    localparam logic [3:0] c_sym_sub = 4'hB;
    localparam logic [3:0] c_sym_mul = 4'hC;
    localparam logic [3:0] c_sym_div = 4'hD;
    localparam logic [3:0] c_sym_clr = 4'hE;
    localparam logic [3:0] c_sym_eq  = 4'hF;

    // Keypad face: 1 2 3 + / 4 5 6 - / 7 8 9 * / C 0 = /
    function automatic logic [3:0] key_symbol(input logic [3:0] code);
        logic [3:0] sym;
        case (code)
            4'd0:    sym = 4'h1;
            4'd1:    sym = 4'h2;
            4'd2:    sym = 4'h3;
            4'd3:    sym = c_sym_add;
            4'd4:    sym = 4'h4;
            4'd5:    sym = 4'h5;
            4'd6:    sym = 4'h6;
            4'd7:    sym = c_sym_sub;
            4'd8:    sym = 4'h7;
            4'd9:    sym = 4'h8;
            4'd10:   sym = 4'h9;
            4'd11:   sym = c_sym_mul;
            4'd12:   sym = c_sym_clr;
            4'd13:   sym = 4'h0;
            4'd14:   sym = c_sym_eq;
            default: sym = c_sym_div;
        endcase
        return sym;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_if.sv
// ============================================================================
// keypad_scanner_if : key handshake between scanner (master) and consumer
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface keypad_scanner_if;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ack;
    logic       key_held;
    logic       overrun;

    modport master (
        output key_code,
        output key_valid,
        output key_held,
        output overrun,
        input  key_ack
    );

    modport slave (
        input  key_code,
        input  key_valid,
        input  key_held,
        input  overrun,
        output key_ack
    );
endinterface

`default_nettype wire

// File: rtl/key_scan_timer.sv
// ============================================================================
// key_scan_timer : row-slot prescaler, row index, one-cold row drive and
//                  column-sample / scan-end strobes
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module key_scan_timer
    import key_pkg::*;
#(
    parameter int SCAN_DIV = 65536
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] row_idx,
    output logic [3:0] row_out,
    output logic       sample,
    output logic       scan_end
);

    localparam int                   c_presc_w   = $clog2(SCAN_DIV);
    localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(SCAN_DIV - 1);

    logic [c_presc_w-1:0] presc_q, presc_d;
    logic [1:0]           row_q, row_d;

    // Sample on the last cycle of the slot so the row drive has settled.
    assign sample   = (presc_q == c_presc_max);
    assign scan_end = sample && (row_q == 2'd3);
    assign row_idx  = row_q;

    always_comb begin
        presc_d = presc_q + c_presc_w'(1);
        row_d   = row_q;
        if (sample) begin
            presc_d = '0;
            row_d   = row_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            row_q   <= 2'd0;
        end else begin
            presc_q <= presc_d;
            row_q   <= row_d;
        end
    end

    always_comb begin
        case (row_q)
            2'd0:    row_out = c_row0_n;
            2'd1:    row_out = c_row1_n;
            2'd2:    row_out = c_row2_n;
            default: row_out = c_row3_n;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// keypad_scanner : 4x4 active-low keypad scan, whole-scan debounce, chord
//                  reject, one-entry valid/ack buffer; KEY_REPEAT_EN adds repeat
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import key_pkg::*;
#(
    parameter int SCAN_DIV       = 65536,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              col_in,
    output logic [3:0]              row_out,
    keypad_scanner_if.master        key_if
);

    localparam logic [3:0] c_deb = 4'(DEBOUNCE_SCANS);

    logic [1:0] w_row_idx;
    logic       w_sample;
    logic       w_scan_end;

    key_scan_timer #(
        .SCAN_DIV (SCAN_DIV)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .row_idx  (w_row_idx),
        .row_out  (row_out),
        .sample   (w_sample),
        .scan_end (w_scan_end)
    );

    // Scan accumulator: low-bit count saturates at 2, code of the first low bit.
    logic [1:0] acc_cnt_q, acc_cnt_d, w_scan_cnt;
    logic [3:0] acc_code_q, acc_code_d, w_scan_code;
    scan_res_e  w_scan_res;

    always_comb begin
        w_scan_cnt  = (w_row_idx == 2'd0) ? 2'd0 : acc_cnt_q;
        w_scan_code = (w_row_idx == 2'd0) ? 4'd0 : acc_code_q;
        for (int c = 0; c < 4; c++) begin
            if (!col_in[c]) begin
                if (w_scan_cnt == 2'd0) w_scan_code = {w_row_idx, 2'(c)};
                if (w_scan_cnt != 2'd2) w_scan_cnt = w_scan_cnt + 2'd1;
            end
        end
        acc_cnt_d  = w_sample ? w_scan_cnt  : acc_cnt_q;
        acc_code_d = w_sample ? w_scan_code : acc_code_q;
        if (w_scan_cnt == 2'd0)      w_scan_res = SCAN_NONE;
        else if (w_scan_cnt == 2'd1) w_scan_res = SCAN_SINGLE;
        else                         w_scan_res = SCAN_MULTI;
    end

    key_state_e state_q, state_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] w_cnt_inc;
    logic       w_accept;
    logic       w_same;

    assign w_cnt_inc = cnt_q + 4'd1;
    assign w_same    = (w_scan_res == SCAN_SINGLE) && (w_scan_code == cand_q);

`ifdef KEY_REPEAT_EN
    localparam int               c_rep_w = $clog2(REPEAT_SCANS + 1);
    localparam logic [c_rep_w-1:0] c_rep = c_rep_w'(REPEAT_SCANS);
    logic [c_rep_w-1:0] rep_q, rep_d;
    logic [c_rep_w-1:0] w_rep_inc;
    assign w_rep_inc = rep_q + c_rep_w'(1);
`else
    logic [31:0] w_unused_repeat;
    assign w_unused_repeat = 32'(REPEAT_SCANS);
`endif

    always_comb begin
        state_d  = state_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
`ifdef KEY_REPEAT_EN
        rep_d    = rep_q;
`endif
        if (w_scan_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (w_scan_res == SCAN_SINGLE) begin
                        cand_d = w_scan_code;
                        cnt_d  = 4'd1;
                        if (c_deb == 4'd1) begin
                            w_accept = 1'b1;
                            state_d  = ST_PRESSED;
                        end else begin
                            state_d  = ST_DEB;
                        end
                    end
                end
                ST_DEB: begin
                    if (w_same) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_deb) begin
                            w_accept = 1'b1;
                            state_d  = ST_PRESSED;
                        end
                    end else if (w_scan_res == SCAN_SINGLE) begin
                        cand_d = w_scan_code;
                        cnt_d  = 4'd1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end
                end
                ST_PRESSED: begin
                    // MULTI or a different single key is not a release.
                    if (w_scan_res == SCAN_NONE) begin
                        cnt_d   = (c_deb == 4'd1) ? 4'd0 : 4'd1;
                        state_d = (c_deb == 4'd1) ? ST_IDLE : ST_REL_DEB;
                    end
`ifdef KEY_REPEAT_EN
                    else if (w_same) begin
                        if (w_rep_inc == c_rep) begin
                            w_accept = 1'b1;
                            rep_d    = '0;
                        end else begin
                            rep_d    = w_rep_inc;
                        end
                    end
`endif
                end
                ST_REL_DEB: begin
                    if (w_scan_res == SCAN_NONE) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == c_deb) begin
                            state_d = ST_IDLE;
                            cnt_d   = 4'd0;
                        end
                    end else begin
                        state_d = ST_PRESSED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef KEY_REPEAT_EN
        if (state_q != ST_PRESSED) rep_d = '0;
`endif
    end

    // One-entry output buffer; an accept coinciding with an ack replaces the entry.
    logic [3:0] code_q, code_d;
    logic       valid_q, valid_d;
    logic       overrun_q, overrun_d;
    logic       w_ack_eff;

    assign w_ack_eff = key_if.key_ack & valid_q;

    always_comb begin
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (w_accept) begin
            if (!valid_q || w_ack_eff) begin
                code_d  = cand_d;
                valid_d = 1'b1;
                if (w_ack_eff) overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (w_ack_eff) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_cnt_q  <= 2'd0;
            acc_code_q <= 4'd0;
            state_q    <= ST_IDLE;
            cand_q     <= 4'd0;
            cnt_q      <= 4'd0;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rep_q      <= '0;
`endif
        end else begin
            acc_cnt_q  <= acc_cnt_d;
            acc_code_q <= acc_code_d;
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
`ifdef KEY_REPEAT_EN
            rep_q      <= rep_d;
`endif
        end
    end

    assign key_if.key_code  = code_q;
    assign key_if.key_valid = valid_q;
    assign key_if.overrun   = overrun_q;
    assign key_if.key_held  = (state_q == ST_PRESSED) || (state_q == ST_REL_DEB);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// ============================================================================
// tb_keypad_scanner : directed keypad stimulus with a queued scoreboard of
//                     expected key presentations (code and edge count)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_in;
    logic [3:0]  row_out;
    logic [15:0] keys;
    int          edge_cnt;
    int          n_checks = 0;
    int          n_pass   = 0;

    typedef struct {
        logic [3:0] code;
        int         at;
    } exp_t;
    exp_t exp_q[$];

    keypad_scanner_if key_if ();

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .REPEAT_SCANS   (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .col_in  (col_in),
        .row_out (row_out),
        .key_if  (key_if)
    );

    always #5 clk = ~clk;

    // Ideal matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [3:0] onecold(input int r);
        logic [3:0] v;
        v = 4'b0001 << r;
        return ~v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
    endtask

    task automatic goto_edge(input int e);
        while (edge_cnt < e) @(negedge clk);
    endtask

    task automatic ack_pulse();
        key_if.key_ack = 1'b1;
        @(negedge clk);
        key_if.key_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        keys = '0;
        key_if.key_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic expect_key(input int code, input int at);
        exp_t e;
        e.code = 4'(code);
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Monitor: a presentation is a fresh key_valid or a reload under ack.
    logic prev_valid_p = 1'b0;
    logic prev_ack_p   = 1'b0;
    always @(posedge clk) begin
        prev_valid_p <= key_if.key_valid;
        prev_ack_p   <= key_if.key_ack;
    end

    always @(negedge clk) begin
        if (!rst && key_if.key_valid && (!prev_valid_p || prev_ack_p)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_key: got code %0d at edge %0d, none expected",
                         key_if.key_code, edge_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (key_if.key_code === e.code && edge_cnt == e.at) n_pass++;
                else $display("FAIL key_present: got code %0d at edge %0d, expected code %0d at edge %0d",
                              key_if.key_code, edge_cnt, e.code, e.at);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        keys = '0;
        key_if.key_ack = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_row_out",  row_out,           4'b1110);
        check("rst_code",     key_if.key_code,   0);
        check("rst_valid",    key_if.key_valid,  0);
        check("rst_held",     key_if.key_held,   0);
        check("rst_overrun",  key_if.overrun,    0);
        rst = 1'b0;

        // Idle scanning
        for (int i = 0; i < 100; i++) begin
            check("idle_row_out", row_out, onecold((edge_cnt / 4) % 4));
            check("idle_valid",   key_if.key_valid, 0);
            @(negedge clk);
        end

        // Clean press of key 9, ack, release
        do_reset();
        keys = 16'h0001 << 9;
        expect_key(9, 32);
        goto_edge(31);
        check("k9_not_early", key_if.key_valid, 0);
        goto_edge(32);
        check("k9_held",  key_if.key_held, 1);
        check("k9_code",  key_if.key_code, 9);
        ack_pulse();
        check("k9_ack_valid", key_if.key_valid, 0);
        goto_edge(48);
        keys = '0;
        goto_edge(79);
        check("k9_held_reldeb", key_if.key_held, 1);
        goto_edge(80);
        check("k9_released", key_if.key_held, 0);

        // Bounce: 1 scan press, 1 scan release, 2 scans press
        do_reset();
        keys = 16'h0001 << 6;
        goto_edge(16);
        keys = '0;
        goto_edge(32);
        keys = 16'h0001 << 6;
        expect_key(6, 64);
        goto_edge(48);
        check("bounce_no_early", key_if.key_valid, 0);
        goto_edge(64);
        keys = '0;
        ack_pulse();
        goto_edge(112);
        check("bounce_idle", key_if.key_held, 0);

        // Chord of keys 3 and 12, then release 12
        do_reset();
        keys = (16'h0001 << 3) | (16'h0001 << 12);
        goto_edge(64);
        check("chord_no_valid", key_if.key_valid, 0);
        check("chord_no_held",  key_if.key_held,  0);
        keys = 16'h0001 << 3;
        expect_key(3, 96);
        goto_edge(80);
        check("chord_no_early", key_if.key_valid, 0);
        goto_edge(96);
        keys = '0;
        ack_pulse();
        goto_edge(144);

        // Overrun and accept-with-ack
        do_reset();
        keys = 16'h0001 << 5;
        expect_key(5, 32);
        goto_edge(32);
        keys = '0;
        goto_edge(64);
        keys = 16'h0001 << 7;
        goto_edge(96);
        check("ovr_code_kept", key_if.key_code,  5);
        check("ovr_flag",      key_if.overrun,   1);
        check("ovr_valid",     key_if.key_valid, 1);
        keys = '0;
        goto_edge(100);
        ack_pulse();
        check("ovr_ack_valid",   key_if.key_valid, 0);
        check("ovr_ack_overrun", key_if.overrun,   0);
        goto_edge(128);
        keys = 16'h0001 << 14;
        expect_key(14, 160);
        goto_edge(160);
        keys = '0;
        goto_edge(192);
        keys = 16'h0001 << 2;
        expect_key(2, 224);
        goto_edge(223);
        ack_pulse();
        check("ackacc_valid",   key_if.key_valid, 1);
        check("ackacc_code",    key_if.key_code,  2);
        check("ackacc_overrun", key_if.overrun,   0);
        keys = '0;
        ack_pulse();
        goto_edge(270);

        // Long hold of key 0 with immediate acks
        do_reset();
        keys = 16'h0001;
        expect_key(0, 32);
`ifdef KEY_REPEAT_EN
        expect_key(0, 80);
        expect_key(0, 128);
`endif
        goto_edge(32);
        ack_pulse();
        goto_edge(80);
        ack_pulse();
        goto_edge(128);
        ack_pulse();
        goto_edge(160);
        keys = '0;
        goto_edge(208);
        check("hold_released", key_if.key_held, 0);

        // Async reset mid-debounce with a pending key and overrun
        do_reset();
        keys = 16'h0001 << 10;
        expect_key(10, 32);
        goto_edge(32);
        keys = '0;
        goto_edge(64);
        keys = 16'h0001 << 11;
        goto_edge(96);
        check("pre_rst_overrun", key_if.overrun, 1);
        keys = '0;
        goto_edge(128);
        keys = 16'h0001 << 1;
        goto_edge(150);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_row_out", row_out,          4'b1110);
        check("midrst_code",    key_if.key_code,  0);
        check("midrst_valid",   key_if.key_valid, 0);
        check("midrst_held",    key_if.key_held,  0);
        check("midrst_overrun", key_if.overrun,   0);
        keys = '0;
        rst  = 1'b0;
        goto_edge(64);
        check("post_rst_valid", key_if.key_valid, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the 7-segment display driver: scans a 4x4 active-low matrix keypad and encodes key presses into 4-bit key codes for the calculator control FSM.
- Scans one row at a time, samples the columns, debounces across whole scans and rejects multi-key chords.
- Presents each accepted key through a one-entry valid/ack buffer with an overrun flag.

Parameters:
- SCAN_DIV, 65536, clk cycles per row slot; a full scan is 4*SCAN_DIV cycles; minimum 2.
- DEBOUNCE_SCANS, 3, consecutive identical full-scan results needed to accept a press or a release; range 1..15.
- REPEAT_SCANS, 64, scans between auto-repeat emissions; used only with KEY_REPEAT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- col_in  in  4  keypad columns, active-low; pulled up externally; already synchronised upstream.
- row_out  out  4  row drive, active-low one-cold: 1110 = row0 … 0111 = row3.
- key_code  out  4  accepted key = row*4 + col; stable while key_valid=1.
- key_valid  out  1  key pending; held high until key_ack.
- key_ack  in  1  consumer pops the pending key; ignored when key_valid=0.
- key_held  out  1  high while the accepted key remains pressed (PRESSED/REL_DEB).
- overrun  out  1  sticky; a key was accepted while one was pending; cleared by key_ack.

Behaviour:
- Reset values: row_out=1110, key_code=0, key_valid=0, key_held=0, overrun=0, prescaler=0, row index=0, state=IDLE, debounce counter=0.
- Timing:
  - Prescaler counts 0..SCAN_DIV-1.
  - Columns are sampled on the cycle where prescaler=SCAN_DIV-1 (settling margin); the row index advances on the next edge, 3 wraps to 0.
- Scan result:
  - A scan is accumulated over rows 0..3.
  - Result at row-3 sample: NONE (no column low in any row), SINGLE(code) (exactly one low bit over all 16 samples), MULTI (otherwise).
  - MULTI is treated as NONE for acceptance, but does not count as release while in PRESSED.
- FSM, evaluated once per scan end:
  - IDLE: SINGLE(c) -> DEB, cand=c, cnt=1; if DEBOUNCE_SCANS=1, accept immediately.
  - DEB:
    - SINGLE(cand) -> cnt+1; at cnt=DEBOUNCE_SCANS accept, go PRESSED.
    - SINGLE(other) -> restart with the new cand, cnt=1.
    - NONE/MULTI -> IDLE.
  - PRESSED: NONE -> REL_DEB, cnt=1. SINGLE(cand) or MULTI -> stay.
  - REL_DEB: NONE -> cnt+1; at DEBOUNCE_SCANS go IDLE. Anything else -> PRESSED.
- Accept effects:
  - Registered; takes effect the cycle after the scan-end sample.
  - If key_valid=0 or key_ack=1 that cycle: key_code<=cand, key_valid<=1.
  - Else: oldest key kept, overrun<=1.
- key_ack with key_valid=1: key_valid<=0 and overrun<=0, unless an accept occurs the same cycle. Accept wins: key_valid stays 1, new code loaded, overrun cleared.
- Latency: a clean press is reported 1 cycle after the end of the DEBOUNCE_SCANS-th consecutive matching scan.
- Async reset mid-scan or mid-debounce returns everything to reset values; a pending key is lost.

Optional Feature:
- KEY_REPEAT_EN defined:
  - In PRESSED with SINGLE(cand), a repeat counter counts scans.
  - Every REPEAT_SCANS scans it re-accepts cand with the same accept/overrun rules.
  - The counter clears on entering PRESSED.
- Undefined: no repeat logic and no counter; exactly one accept per press.

Decomposition:
- Shared package key_pkg:
  - state enum (IDLE, DEB, PRESSED, REL_DEB);
  - scan-result enum (NONE, SINGLE, MULTI);
  - one-cold row constants;
  - calculator legend constants mapping codes to digits 0-9 and operators A-F, also used by the control FSM.
- One natural sub-module, key_scan_timer: prescaler, row index, row_out, and sample/scan_end strobes.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3):
- Reset, no keys, 100 cycles -> row_out cycles 1110,1101,1011,0111 every 4 cycles; key_valid=0.
- Hold row2/col1 (col_in=1101 while row_out=1011) from scan start -> key_code=9, key_valid=1 one cycle after the 2nd scan end; key_held=1. Ack -> key_valid=0. Release -> key_held=0 after 2 NONE scans.
- Bounce: press 1 scan, release 1 scan, press 2 scans -> single acceptance, timed from the final stable pair; no extra key_valid.
- Press key 3 and key 12 together for 4 scans -> no accept. Release key 12 -> code 3 accepted after 2 scans.
- Accept key 5, no ack; press, release and re-press key 7 -> key_code stays 5, overrun=1. Ack -> overrun=0, key_valid=0. Also: ack in the same cycle as an accept -> new code loaded, key_valid stays 1.
- KEY_REPEAT_EN: hold key 0 for 10 scans with immediate acks -> initial accept plus repeats every 3 scans. Assert rst mid-DEB -> all outputs at reset values next cycle.
